// File: rtl/uart_msg_arbiter.sv
// uart_msg_arbiter: round-robin arbiter that streams fixed-slot ROM messages to a UART transmitter.
//
// Each requester i owns a ROM slot of MSG_LEN bytes starting at i*MSG_LEN. Once granted, bytes are
// fetched and handed to the UART one at a time until a 8'h00 terminator is read or MSG_LEN bytes
// have gone out. A grant is never preempted. If the UART fails to acknowledge a start within
// ACK_TIMEOUT cycles the message is abandoned and a sticky error flag is raised.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       asynchronous active-high reset
//   req_i       per-requester send request, level-sampled every cycle
//   rom_addr_o  message ROM byte address (cur_id*MSG_LEN + byte index)
//   rom_data_i  ROM byte at rom_addr_o, combinational
//   tx_start_o  one-cycle start pulse to the UART
//   tx_data_o   byte to transmit, held until the next byte is loaded
//   tx_busy_i   UART busy flag
//   done_o      one-cycle pulse on the bit of the requester whose message finished
//   cur_id_o    requester currently granted
//   busy_o      high whenever the arbiter is not idle
//   err_o       sticky acknowledge-timeout flag
module uart_msg_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MSG_LEN     = 18,
  parameter int unsigned ACK_TIMEOUT = 16,
  localparam int unsigned IW = $clog2(NUM_REQ),
  localparam int unsigned AW = $clog2(NUM_REQ * MSG_LEN)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [AW-1:0]      rom_addr_o,
  input  logic [7:0]         rom_data_i,
  output logic               tx_start_o,
  output logic [7:0]         tx_data_o,
  input  logic               tx_busy_i,
  output logic [NUM_REQ-1:0] done_o,
  output logic [IW-1:0]      cur_id_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam int unsigned BW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StStart,
    StWaitAck,
    StWaitDone,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [IW-1:0]      last_grant_q, last_grant_d;
  logic [IW-1:0]      cur_id_q, cur_id_d;
  logic [BW-1:0]      byte_idx_q, byte_idx_d;
  logic [CW-1:0]      ack_cnt_q, ack_cnt_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               err_q, err_d;

  // Round-robin pick: first pending bit at or after last_grant+1, wrapping. NUM_REQ is a power
  // of two, so the IW-bit sum wraps modulo NUM_REQ for free.
  logic [IW-1:0] rr_idx;
  logic [IW-1:0] grant_id;
  logic          grant_vld;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    rr_idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      rr_idx = last_grant_q + IW'(k);
      if (!grant_vld && pending_q[rr_idx]) begin
        grant_vld = 1'b1;
        grant_id  = rr_idx;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
      cur_id_q     <= '0;
      byte_idx_q   <= '0;
      ack_cnt_q    <= '0;
      tx_data_q    <= 8'h00;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      cur_id_q     <= cur_id_d;
      byte_idx_q   <= byte_idx_d;
      ack_cnt_q    <= ack_cnt_d;
      tx_data_q    <= tx_data_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_id_d     = cur_id_q;
    byte_idx_d   = byte_idx_q;
    ack_cnt_d    = ack_cnt_q;
    tx_data_d    = tx_data_q;
    err_d        = err_q;

    // Completion clears the finished requester, but a request in the same cycle re-arms it.
    pending_d = pending_q;
    if (state_q == StDone) begin
      pending_d[cur_id_q] = 1'b0;
    end
    pending_d = pending_d | req_i;

    case (state_q)
      StIdle: begin
        if (grant_vld) begin
          cur_id_d   = grant_id;
          byte_idx_d = '0;
          state_d    = StFetch;
        end
      end
      StFetch: begin
        if (rom_data_i == 8'h00) begin
          state_d = StDone;
        end else if (!tx_busy_i) begin
          tx_data_d = rom_data_i;
          state_d   = StStart;
        end
      end
      StStart: begin
        ack_cnt_d = '0;
        state_d   = StWaitAck;
      end
      StWaitAck: begin
        if (tx_busy_i) begin
          state_d = StWaitDone;
        end else if (ack_cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          // The UART never took the byte: abandon the rest of the message.
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          ack_cnt_d = ack_cnt_q + CW'(1);
        end
      end
      StWaitDone: begin
        if (!tx_busy_i) begin
          if (byte_idx_q == BW'(MSG_LEN - 1)) begin
            state_d = StDone;
          end else begin
            byte_idx_d = byte_idx_q + BW'(1);
            state_d    = StFetch;
          end
        end
      end
      StDone: begin
        last_grant_d = cur_id_q;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    tx_start_o = (state_q == StStart);
    busy_o     = (state_q != StIdle);
    done_o     = '0;
    if (state_q == StDone) begin
      done_o[cur_id_q] = 1'b1;
    end
  end

  assign rom_addr_o = AW'(cur_id_q) * AW'(MSG_LEN) + AW'(byte_idx_q);
  assign tx_data_o  = tx_data_q;
  assign cur_id_o   = cur_id_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Self-checking bench for uart_msg_arbiter: a transaction-level model (pending set, round-robin
// pick, expected byte list per grant) checked every cycle, plus directed literal expectations.
module tb_uart_msg_arbiter;

  localparam int NReq   = 4;
  localparam int MsgLen = 18;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [6:0] rom_addr;
  logic [7:0] rom_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [3:0] done;
  logic [1:0] cur_id;
  logic       busy;
  logic       err;

  logic [7:0] rom [0:71];
  logic       uart_busy;
  logic       force_busy;
  bit         uart_stuck;

  assign rom_data = (int'(rom_addr) < 72) ? rom[rom_addr] : 8'h00;
  assign tx_busy  = uart_busy | force_busy;

  uart_msg_arbiter #(
    .NUM_REQ    (4),
    .MSG_LEN    (18),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .rom_addr_o(rom_addr),
    .rom_data_i(rom_data),
    .tx_start_o(tx_start),
    .tx_data_o (tx_data),
    .tx_busy_i (tx_busy),
    .done_o    (done),
    .cur_id_o  (cur_id),
    .busy_o    (busy),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // UART: busy from the edge after a start pulse for 10 cycles; stuck mode never acknowledges.
  initial begin
    uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && tx_start && !uart_stuck) begin
        @(posedge clk);
        #1 uart_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 uart_busy = 1'b0;
      end
    end
  end

  // ---------------- model ----------------
  logic [3:0] m_pend = '0;
  logic [3:0] m_clr  = '0;
  int         m_last = NReq - 1;
  bit         m_active = 1'b0;
  int         m_id = 0;
  int         m_k = 0;
  bit         m_abort = 1'b0;
  bit         m_err = 1'b0;
  bit         m_done_now;
  logic [7:0] m_bytes[$];
  int         grant_log[$];
  int         addr_log[$];

  function automatic int rr_pick(input logic [3:0] p, input int last);
    for (int k = 1; k <= NReq; k++) begin
      int i;
      i = (last + k) % NReq;
      if (p[i]) return i;
    end
    return 0;
  endfunction

  // Pending set as seen by the arbiter: requests set, a completed grant clears, set wins.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) m_pend = '0;
      else     m_pend = (m_pend & ~m_clr) | req;
    end
  end

  // Compare process: every non-reset cycle, at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_clr    = '0;
        m_last   = NReq - 1;
        m_active = 1'b0;
        m_err    = 1'b0;
        m_abort  = 1'b0;
        m_k      = 0;
        m_id     = 0;
      end else begin
        m_done_now = 1'b0;
        chk("busy", busy, m_active);
        if (m_active) chk("cur_id", cur_id, m_id);
        if (tx_start) begin
          chk("tx_start_expected", (m_active && m_k < m_bytes.size()), 1);
          if (m_active && m_k < m_bytes.size()) begin
            chk("tx_data", tx_data, m_bytes[m_k]);
            chk("rom_addr", rom_addr, m_id * MsgLen + m_k);
            addr_log.push_back(int'(rom_addr));
            m_k++;
          end
        end
        m_clr = '0;
        if (done != 4'b0000) begin
          m_done_now = 1'b1;
          chk("done_expected", m_active, 1);
          if (m_active) begin
            chk("done_vec", done, 1 << m_id);
            chk("done_byte_count", m_k, m_bytes.size());
            if (m_abort) m_err = 1'b1;
            grant_log.push_back(m_id);
            m_clr    = 4'(1 << m_id);
            m_last   = m_id;
            m_active = 1'b0;
          end
        end
        chk("err", err, m_err);
        // Idle cycle with something pending: the next edge grants.
        if (!m_active && !m_done_now && m_pend != 4'b0000) begin
          m_id = rr_pick(m_pend, m_last);
          m_bytes.delete();
          for (int j = 0; j < MsgLen; j++) begin
            if (rom[m_id * MsgLen + j] == 8'h00) break;
            m_bytes.push_back(rom[m_id * MsgLen + j]);
          end
          m_abort = uart_stuck && (m_bytes.size() > 0);
          if (m_abort) begin
            while (m_bytes.size() > 1) void'(m_bytes.pop_back());
          end
          m_k      = 0;
          m_active = 1'b1;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_rom();
    for (int i = 0; i < 72; i++) rom[i] = 8'h00;
  endtask

  task automatic load_str(input int slot, input string s);
    for (int i = 0; i < s.len(); i++) rom[slot * MsgLen + i] = s[i];
  endtask

  task automatic pulse_req(input logic [3:0] v);
    @(posedge clk);
    #1 req = v;
    @(posedge clk);
    #1 req = 4'b0000;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (done == 4'b0000 && cycles < budget);
    chk("done_within_budget", (done != 4'b0000), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int cyc;
    int exp_order[5];
    int n_evt;

    rst        = 1'b1;
    req        = 4'b0000;
    force_busy = 1'b0;
    uart_stuck = 1'b0;
    clear_rom();
    load_str(0, "MUL supported\n");
    #3;
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_done", done, 4'b0000);
    chk("rst_cur_id", cur_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rom_addr", rom_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single request with latency pinning.
    addr_log.delete();
    @(posedge clk);
    #1 req = 4'b0001;
    @(posedge clk);
    #1 req = 4'b0000;
    @(negedge clk);
    chk("lat_idle_busy", busy, 0);
    chk("lat_idle_tx_start", tx_start, 0);
    @(negedge clk);
    chk("lat_fetch_busy", busy, 1);
    chk("lat_fetch_tx_start", tx_start, 0);
    @(negedge clk);
    chk("lat_start_tx_start", tx_start, 1);
    chk("lat_start_tx_data", tx_data, 8'h4D);
    wait_done(600, cyc);
    chk("t1_done_vec", done, 4'b0001);
    @(negedge clk);
    #1;
    chk("t1_byte_count", addr_log.size(), 14);
    chk("t1_last_addr", addr_log[13], 13);
    chk("t1_busy_after", busy, 0);
    chk("t1_done_cleared", done, 4'b0000);

    // Round-robin from a fresh reset.
    do_reset();
    clear_rom();
    load_str(0, "a0");
    load_str(1, "b1");
    load_str(2, "c2");
    load_str(3, "d3");
    grant_log.delete();
    pulse_req(4'b1011);
    repeat (3) wait_done(200, cyc);
    pulse_req(4'b1001);
    repeat (2) wait_done(200, cyc);
    @(negedge clk);
    #1;
    exp_order = '{0, 1, 3, 0, 3};
    chk("rr_count", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
      chk($sformatf("rr_order_%0d", i), grant_log[i], exp_order[i]);
    end

    // Full-length message, no terminator.
    for (int j = 0; j < MsgLen; j++) rom[2 * MsgLen + j] = 8'(8'h41 + j);
    addr_log.delete();
    pulse_req(4'b0100);
    wait_done(600, cyc);
    chk("t3_done_vec", done, 4'b0100);
    @(negedge clk);
    #1;
    chk("t3_byte_count", addr_log.size(), 18);
    chk("t3_first_addr", addr_log[0], 36);
    chk("t3_last_addr", addr_log[addr_log.size() - 1], 53);

    // Acknowledge timeout.
    uart_stuck = 1'b1;
    pulse_req(4'b0010);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tx_start && cyc < 50);
    chk("t4_start_seen", tx_start, 1);
    wait_done(40, cyc);
    chk("t4_timeout_cycles", cyc, 17);
    chk("t4_err_set", err, 1);
    chk("t4_done_vec", done, 4'b0010);
    uart_stuck = 1'b0;
    pulse_req(4'b0001);
    wait_done(200, cyc);
    chk("t4_next_done_vec", done, 4'b0001);
    chk("t4_err_sticky", err, 1);

    // Busy-hold: UART busy on FETCH entry.
    force_busy = 1'b1;
    pulse_req(4'b1000);
    repeat (6) begin
      @(negedge clk);
      chk("hold_no_start", tx_start, 0);
    end
    chk("hold_busy", busy, 1);
    chk("hold_rom_addr", rom_addr, 54);
    @(posedge clk);
    #1 force_busy = 1'b0;
    @(negedge clk);
    chk("hold_fall_cycle", tx_start, 0);
    @(negedge clk);
    chk("hold_start_after_fall", tx_start, 1);
    wait_done(200, cyc);
    chk("hold_done_vec", done, 4'b1000);

    // Reset mid-message with another request pending.
    clear_rom();
    load_str(0, "MUL supported\n");
    load_str(1, "b1");
    addr_log.delete();
    pulse_req(4'b0001);
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (addr_log.size() < 5 && cyc < 400);
    chk("t6_five_bytes", addr_log.size(), 5);
    pulse_req(4'b0010);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_tx_start", tx_start, 0);
    chk("t6_rst_tx_data", tx_data, 8'h00);
    chk("t6_rst_done", done, 4'b0000);
    chk("t6_rst_cur_id", cur_id, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_rom_addr", rom_addr, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_evt = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_start || done != 4'b0000 || busy) n_evt++;
    end
    chk("t6_quiet_after_reset", n_evt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_msg_arbiter.md
UART_MSG_ARBITER -- requirements
Module: uart_msg_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters; must be a power of two, at least 2.
REQ-002 SHALL have parameter MSG_LEN, default 18: byte slots per message, and the maximum message length.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 16: the number of cycles to wait for tx_busy after tx_start.
REQ-004 SHALL define IW = clog2(NUM_REQ) and AW = clog2(NUM_REQ*MSG_LEN).
REQ-005 clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 req  in  NUM_REQ  per-requester send request; level-sampled each cycle.
REQ-008 rom_addr  out  AW  message-ROM byte address = cur_id*MSG_LEN + byte_idx; combinational from registers.
REQ-009 rom_data  in  8  ROM byte at rom_addr; combinational, valid the same cycle.
REQ-010 tx_start  out  1  one-cycle start pulse to the UART transmitter.
REQ-011 tx_data  out  8  byte to transmit; held stable from the tx_start cycle until the next load.
REQ-012 tx_busy  in  1  transmitter busy flag.
REQ-013 done  out  NUM_REQ  one-cycle pulse on the bit of the requester whose message completed.
REQ-014 cur_id  out  IW  requester currently granted.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 err  out  1  sticky acknowledge-timeout flag.

Function
REQ-017 SHALL hold pending[NUM_REQ]:
 - any cycle with req[i]=1 sets pending[i];
 - pending[i] clears in the DONE cycle for i;
 - if req[i]=1 in that same DONE cycle, the set wins.
REQ-018 SHALL implement FSM states IDLE, FETCH, START, WAIT_ACK, WAIT_DONE, DONE.
REQ-019 IDLE:
 - if pending≠0, grant round-robin: the first set pending bit searched from (last_grant+1) mod NUM_REQ upward, with wrap-around;
 - load cur_id, byte_idx←0, go to FETCH;
 - otherwise stay in IDLE.
REQ-020 FETCH:
 - rom_data==8'h00 → DONE (terminator; nothing sent);
 - else if tx_busy=0 → latch tx_data←rom_data, go to START;
 - else stay in FETCH.
REQ-021 START: tx_start=1 for exactly this one cycle; clear the timeout counter; go to WAIT_ACK.
REQ-022 WAIT_ACK:
 - tx_busy=1 → WAIT_DONE;
 - else increment the counter; at ACK_TIMEOUT cycles set err←1 and go to DONE (the message is abandoned).
REQ-023 WAIT_DONE: on tx_busy=0, byte_idx←byte_idx+1; if the old byte_idx == MSG_LEN-1 → DONE, else → FETCH.
REQ-024 DONE: done[cur_id]=1 for one cycle; last_grant←cur_id; go to IDLE.
REQ-025 Latency, with tx_busy=0:
 - req rising at edge n → pending set at n;
 - FETCH from edge n+1;
 - START (tx_start high) from edge n+2.
REQ-026 tx_start SHALL never assert when tx_busy was 1 in the preceding FETCH cycle; at most one tx_start per byte.
REQ-027 SHALL send at most MSG_LEN bytes per grant, with no 8'h00 byte ever transmitted.
REQ-028 A grant SHALL never be preempted; requests arriving mid-message only set pending.
REQ-029 err SHALL stay at 1 until reset; operation continues normally after err is set.
REQ-030 byte_idx SHALL be wide enough for MSG_LEN-1 and never exceed it.

Reset
REQ-031 While rst=1, asynchronously and independent of clk:
 - state=IDLE;
 - pending=0, byte_idx=0;
 - last_grant=NUM_REQ-1, so requester 0 has first priority;
 - tx_start=0, tx_data=8'h00, done=0;
 - cur_id=0, busy=0, err=0.
REQ-032 Reset asserted mid-message SHALL:
 - drop the message and all pending requests;
 - emit no done pulse;
 - leave tx_start low from the reset edge onward.

Verification
REQ-033 Single request: ROM slot 0 = "MUL supported\n",00, UART model busy 10 cycles per byte; req=4'b0001 for one cycle → 14 tx_start pulses carrying the bytes in order, then done=4'b0001 for one cycle, busy=0.
REQ-034 Round-robin: req=4'b1011 held for one cycle, all messages 2 bytes → grants in order 0, 1, 3; then req=4'b1001 → grant 3 is skipped in favour of 0 first (last_grant=3 wraps to 0), then 3.
REQ-035 Full-length message: slot 2 has no terminator → exactly 18 bytes sent; rom_addr runs 36..53; done[2] pulses.
REQ-036 Timeout: tx_busy stuck at 0 after tx_start → after 16 cycles in WAIT_ACK, err=1 and done[cur_id] pulses; a subsequent request still completes with err remaining 1.
REQ-037 Busy-hold: tx_busy=1 when FETCH is entered → no tx_start until tx_busy falls; then tx_start occurs 2 cycles later.
REQ-038 Reset: assert rst during byte 5 of a message with req[1] pending → all outputs at reset values immediately; after release with no req, the FSM stays in IDLE and sends no byte.
